// File: rtl/s_16bit_unfold.sv
// Rebuilds 16-bit words a/b from a low-half beat followed by an XOR-folded beat.
// Output is registered (1-cycle latency); input stalls only on the folded beat while the output is held.
module s_16bit_unfold #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [7:0]       in_x,
   input  logic [7:0]       in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      a,
   output logic [15:0]      b,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [7:0]       lo_x_q, lo_x_d;
   logic [7:0]       lo_y_q, lo_y_d;
   logic             out_valid_q, out_valid_d;
   logic [15:0]      a_q, a_d;
   logic [15:0]      b_q, b_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             acc;
   logic             drop_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LO;
         lo_x_q      <= '0;
         lo_y_q      <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         lo_x_q      <= lo_x_d;
         lo_y_q      <= lo_y_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         drop_q      <= drop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lo_x_d      = lo_x_q;
      lo_y_d      = lo_y_q;
      out_valid_d = out_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      drop_d      = drop_q;
      drop_inc    = 1'b0;

      // Low beats never need the output register, so only HI can stall.
      in_ready = (state_q == LO) || !out_valid_q || out_ready;
      acc      = in_valid && in_ready;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         LO: begin
            if (acc) begin
               if (in_sof) begin
                  lo_x_d  = in_x;
                  lo_y_d  = in_y;
                  state_d = HI;
               end else begin
                  drop_inc = 1'b1;
               end
            end
         end
         HI: begin
            if (acc) begin
               if (in_sof) begin
                  // Resync: previous low halves are abandoned in favour of the new ones.
                  drop_inc = 1'b1;
                  lo_x_d   = in_x;
                  lo_y_d   = in_y;
               end else begin
                  a_d         = {in_x ^ lo_x_q, lo_x_q};
                  b_d         = {in_y ^ lo_y_q, lo_y_q};
                  out_valid_d = 1'b1;
                  state_d     = LO;
               end
            end
         end
      endcase

      if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
         drop_d = drop_q + CNT_W'(1);
      end
   end

   assign out_valid = out_valid_q;
   assign a         = a_q;
   assign b         = b_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_s_16bit_unfold.sv
// Bench for s_16bit_unfold: directed literal cases plus randomized traffic against a word-level model.
module tb_s_16bit_unfold;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sof = 1'b0;
   logic [7:0]  in_x = 8'h00;
   logic [7:0]  in_y = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] a;
   logic [15:0] b;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   s_16bit_unfold #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .b(b), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Word-level model: pending low halves, the word currently presented, and a drop tally.
   bit        m_have = 0;
   logic [7:0] m_lx = 0, m_ly = 0;
   bit        m_ov = 0;
   logic [15:0] m_a = 0, m_b = 0;
   int        m_drop = 0;

   always @(posedge clk or posedge rst) begin
      bit take;
      if (rst) begin
         m_have = 0; m_lx = 0; m_ly = 0; m_ov = 0; m_a = 0; m_b = 0; m_drop = 0;
      end else begin
         take = in_valid && (!m_have || !m_ov || out_ready);
         if (m_ov && out_ready) m_ov = 0;
         if (take) begin
            if (in_sof) begin
               if (m_have) m_drop++;
               m_have = 1; m_lx = in_x; m_ly = in_y;
            end else if (m_have) begin
               m_a = {in_x ^ m_lx, m_lx};
               m_b = {in_y ^ m_ly, m_ly};
               m_ov = 1; m_have = 0;
            end else begin
               m_drop++;
            end
         end
         if (m_drop > 255) m_drop = 255;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("mdl_in_ready", 32'(in_ready), 32'(!m_have || !m_ov || out_ready));
         chk("mdl_out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov) begin
            chk("mdl_a", 32'(a), 32'(m_a));
            chk("mdl_b", 32'(b), 32'(m_b));
         end
         chk("mdl_drop", 32'(drop_cnt), 32'(m_drop));
      end
   end

   // Offer one beat and hold it until accepted; returns just after the accepting edge.
   task automatic beat(input logic sof, input logic [7:0] x, input logic [7:0] y);
      bit done = 0;
      in_valid = 1'b1; in_sof = sof; in_x = x; in_y = y;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            done = 1;
         end
      end
      if (!done) chk("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] wa, input logic [15:0] wb);
      beat(1'b1, wa[7:0], wb[7:0]);
      beat(1'b0, wa[7:0] ^ wa[15:8], wb[7:0] ^ wb[15:8]);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #3 rst = 1'b1;
      #4 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   logic [15:0] wa_tab [4] = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00};
   logic [15:0] wb_tab [4] = '{16'hFF00, 16'h00FF, 16'h1234, 16'hFFFF};

   initial begin
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_a", 32'(a), 32'd0);
      chk("rst_b", 32'(b), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Basic reconstruction
      out_ready = 1'b1;
      beat(1'b1, 8'h5A, 8'h34);
      beat(1'b0, 8'hFF, 8'h26);
      idle();
      chk("basic_ov", 32'(out_valid), 32'd1);
      chk("basic_a", 32'(a), 32'hA55A);
      chk("basic_b", 32'(b), 32'h1234);
      chk("basic_drop", 32'(drop_cnt), 32'd0);
      @(posedge clk); #1;

      // Back-to-back streaming
      for (int w = 0; w < 4; w++) begin
         beat(1'b1, wa_tab[w][7:0], wb_tab[w][7:0]);
         chk("b2b_ov_low", 32'(out_valid), 32'(w == 0 ? 0 : 0));
         chk("b2b_rdy", 32'(in_ready), 32'd1);
         beat(1'b0, wa_tab[w][7:0] ^ wa_tab[w][15:8], wb_tab[w][7:0] ^ wb_tab[w][15:8]);
         chk("b2b_ov", 32'(out_valid), 32'd1);
         chk("b2b_a", 32'(a), 32'(wa_tab[w]));
         chk("b2b_b", 32'(b), 32'(wb_tab[w]));
      end
      idle();
      @(posedge clk); #1;

      // Backpressure
      send_word(16'hA55A, 16'h1234);
      idle();
      out_ready = 1'b0;
      beat(1'b1, 8'hEF, 8'hFE);
      chk("bp_low_acc_ov", 32'(out_valid), 32'd1);
      in_valid = 1'b1; in_sof = 1'b0; in_x = 8'hEF ^ 8'hBE; in_y = 8'hFE ^ 8'hCA;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_a_hold", 32'(a), 32'hA55A);
         chk("bp_b_hold", 32'(b), 32'h1234);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      beat(1'b0, 8'hEF ^ 8'hBE, 8'hFE ^ 8'hCA);
      idle();
      chk("bp_ov2", 32'(out_valid), 32'd1);
      chk("bp_a2", 32'(a), 32'hBEEF);
      chk("bp_b2", 32'(b), 32'hCAFE);

      // Framing errors
      pulse_reset();
      beat(1'b0, 8'h77, 8'h00);
      idle();
      chk("orphan_drop", 32'(drop_cnt), 32'd1);
      beat(1'b1, 8'h11, 8'h00);
      beat(1'b1, 8'h22, 8'h00);
      beat(1'b0, 8'h33, 8'h00);
      idle();
      chk("resync_drop", 32'(drop_cnt), 32'd2);
      chk("resync_a", 32'(a), 32'h1122);
      chk("resync_ov", 32'(out_valid), 32'd1);

      // Saturation
      for (int i = 0; i < 300; i++) beat(1'b0, 8'(i), 8'(i));
      idle();
      chk("sat_drop", 32'(drop_cnt), 32'hFF);
      @(posedge clk); #1;
      chk("sat_hold", 32'(drop_cnt), 32'hFF);

      // Randomized traffic, checked by the model every cycle
      pulse_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sof    = ($urandom_range(0, 9) < 4);
         in_x      = 8'($urandom);
         in_y      = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      idle();

      // Reset mid-operation: HI with output held
      out_ready = 1'b1;
      send_word(16'h4321, 16'h8765);
      idle();
      out_ready = 1'b0;
      beat(1'b1, 8'h01, 8'h02);
      idle();
      chk("pre_rst_ov", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_ov", 32'(out_valid), 32'd0);
      chk("async_a", 32'(a), 32'd0);
      chk("async_b", 32'(b), 32'd0);
      chk("async_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      beat(1'b1, 8'h5A, 8'h34);
      beat(1'b0, 8'hFF, 8'h26);
      idle();
      chk("post_rst_a", 32'(a), 32'hA55A);
      chk("post_rst_b", 32'(b), 32'h1234);
      chk("post_rst_ov", 32'(out_valid), 32'd1);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
